// File: rtl/text_normalizer.sv
// Byte-stream normalizer ahead of the begin/end checker: lower-cases letters,
// collapses whitespace runs to one space, drops non-printables, buffers in a FWFT FIFO.
module text_normalizer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic [15:0]   drop_cnt
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE        = (AW+1)'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [15:0]   drop_cnt_reg;
  logic          prev_sep_reg;

  logic       accept, is_upper, is_print, is_sep;
  logic       push, pop, drop, sep_push;
  logic [7:0] push_data;

  assign in_ready  = (count_reg != FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign out_data  = out_valid ? mem[rd_ptr_reg] : 8'h00;
  assign count     = count_reg;
  assign drop_cnt  = drop_cnt_reg;

  assign accept   = in_valid && in_ready && !flush;
  assign is_upper = (in_data >= 8'h41) && (in_data <= 8'h5A);
  assign is_print = (in_data >= 8'h21) && (in_data <= 8'h7E);
  assign is_sep   = (in_data == 8'h20) || (in_data == 8'h09) ||
                    (in_data == 8'h0A) || (in_data == 8'h0D);

  // A separator only produces a space when it ends a run of real characters.
  assign sep_push  = accept && is_sep && !prev_sep_reg;
  assign push      = (accept && is_print) || sep_push;
  assign drop      = accept && !is_print && !is_sep;
  assign pop       = out_valid && out_ready && !flush;
  assign push_data = is_sep ? 8'h20 : (is_upper ? in_data + 8'h20 : in_data);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + ONE;
      2'b01:   count_next = count_reg - ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_cnt_reg <= '0;
      prev_sep_reg <= 1'b1;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      prev_sep_reg <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (accept && is_print) prev_sep_reg <= 1'b0;
      else if (sep_push)      prev_sep_reg <= 1'b1;
      if (drop && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_text_normalizer.sv
// Directed-vector bench for text_normalizer: case fold, whitespace collapse,
// drops, backpressure, pointer wrap, flush and reset.
module tb_text_normalizer;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [3:0]  count;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;
  logic [7:0] stim[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  text_normalizer #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Feed stim one byte per clock with out_ready=1 and collect every visible output.
  task automatic run_stream;
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < stim.size(); i++) begin
      in_data  = stim[i];
      in_valid = 1'b1;
      tick();
      if (out_valid) got.push_back(out_data);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid) got.push_back(out_data);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 8'h00);
    check("rst_drop_cnt", drop_cnt, 0);

    // Case fold: each char visible one cycle after its input edge
    stim = '{8'h42, 8'h65, 8'h47, 8'h69, 8'h4E};
    exp_q = '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = stim[i]; in_valid = 1'b1;
      tick();
      check($sformatf("fold_data_%0d", i), out_data, exp_q[i]);
      check($sformatf("fold_count_%0d", i), count, 1);
    end
    in_valid = 1'b0;
    tick();
    check("fold_empty", out_valid, 0);
    check("fold_drop_cnt", drop_cnt, 0);

    // Whitespace collapse after flush (leading spaces suppressed)
    flush = 1'b1; tick(); flush = 1'b0;
    stim  = '{8'h20, 8'h20, 8'h61, 8'h20, 8'h09, 8'h0D, 8'h0A, 8'h20, 8'h62};
    exp_q = '{8'h61, 8'h20, 8'h62};
    run_stream();
    check_stream("ws");

    // Drops
    stim  = '{8'h65, 8'h07, 8'h80, 8'h6E, 8'h7F, 8'h64};
    exp_q = '{8'h65, 8'h6E, 8'h64};
    run_stream();
    check_stream("drop");
    check("drop_cnt3", drop_cnt, 3);

    // Full / backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h61 + 8'(i); in_valid = 1'b1;
      tick();
    end
    check("full_count", count, 8);
    check("full_in_ready", in_ready, 0);
    in_data = 8'h69;
    tick(); tick();
    check("full_held_count", count, 8);
    in_valid = 1'b0;
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) got.push_back(out_data);
      tick();
      if (i == 0) begin
        check("bp_first_pop_in_ready", in_ready, 1);
        check("bp_first_pop_count", count, 7);
      end
    end
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    check_stream("drain");
    check("drain_count", count, 0);

    // Wrap with simultaneous push/pop
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'h61 + 8'(i); in_valid = 1'b1;
      tick();
      check($sformatf("wrap_count_%0d", i), count, 1);
      check($sformatf("wrap_data_%0d", i), out_data, 8'h61 + 8'(i));
    end
    in_valid = 1'b0;
    tick();
    check("wrap_empty", count, 0);

    // Flush mid-stream with a byte presented
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h70 + 8'(i); in_valid = 1'b1;
      tick();
    end
    check("pre_flush_count", count, 5);
    flush = 1'b1; in_data = 8'h78; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_data", out_data, 8'h00);
    check("flush_drop_cnt", drop_cnt, 3);
    flush = 1'b1; in_data = 8'h07; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_ctrl_drop_cnt", drop_cnt, 3);
    stim  = '{8'h20, 8'h61};
    exp_q = '{8'h61};
    run_stream();
    check_stream("post_flush");

    // Reset overrides flush/push in the same cycle
    out_ready = 1'b0;
    in_data = 8'h41; in_valid = 1'b1;
    tick();
    check("pre_reset_count", count, 1);
    reset = 1'b1; flush = 1'b1; in_data = 8'h07; in_valid = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("reset_drop_cnt", drop_cnt, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_count", count, 0);
    stim  = '{8'h20, 8'h51};
    exp_q = '{8'h71};
    run_stream();
    check_stream("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
